// File: rtl/out_checker_if.sv
// out_checker_if -- expectation push channel for out_checker.
//
// Signals:
//   exp_valid / exp_ready  push handshake (entry accepted when both high)
//   exp_stamp  [CW-1:0]    run cycle index at which the entry is checked
//   exp_mask   [3:0]       channel enables, bit0=a .. bit3=d
//   exp_a..exp_d [7:0]     expected channel values
//
// Modports: master drives an entry (testbench / sequencer), slave receives it
// (out_checker).
interface out_checker_if #(
    parameter int unsigned CW = 16
);
    logic          exp_valid;
    logic          exp_ready;
    logic [CW-1:0] exp_stamp;
    logic [3:0]    exp_mask;
    logic [7:0]    exp_a;
    logic [7:0]    exp_b;
    logic [7:0]    exp_c;
    logic [7:0]    exp_d;

    modport master (
        output exp_valid, exp_stamp, exp_mask, exp_a, exp_b, exp_c, exp_d,
        input  exp_ready
    );

    modport slave (
        input  exp_valid, exp_stamp, exp_mask, exp_a, exp_b, exp_c, exp_d,
        output exp_ready
    );
endinterface

// File: rtl/out_checker.sv
// out_checker -- cycle-stamped output checker for an upstream design.
//
// Expectations (stamp, channel mask, four expected bytes) are queued in a
// small FIFO at any time. A start pulse begins a run of run_len cycles; during
// the run the head entry is compared against the observed a..d when its stamp
// equals the run cycle counter, or discarded as missed once the counter has
// passed its stamp. Mismatches accumulate in a saturating 8-bit counter.
//
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   a, b, c, d          observed upstream outputs
//   start, run_len      run start pulse and length (0 behaves as 1)
//   exp_if (slave)      expectation push channel
//   busy, done, pass    run state and verdict
//   err_cnt, missed     mismatch count (saturating), sticky missed-stamp flag
//   fail_cycle/chan     first-failure trace
//
// Build option: define OUT_CHECKER_TRACE_EN to build the first-failure trace
// registers; otherwise fail_cycle and fail_chan are tied to 0.
module out_checker #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CW    = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    a,
    input  logic [7:0]    b,
    input  logic [7:0]    c,
    input  logic [7:0]    d,
    input  logic          start,
    input  logic [CW-1:0] run_len,
    out_checker_if.slave  exp_if,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic [7:0]    err_cnt,
    output logic          missed,
    output logic [CW-1:0] fail_cycle,
    output logic [1:0]    fail_chan
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FullCnt = (AW + 1)'(DEPTH);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StRun  = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cyc_q, cyc_d;
    logic [CW-1:0] last_q, last_d;
    logic [7:0]    err_q, err_d;
    logic          missed_q, missed_d;

    // Expectation FIFO
    logic [CW-1:0] stamp_mem [DEPTH];
    logic [3:0]    mask_mem  [DEPTH];
    logic [31:0]   data_mem  [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q, count_d;

    logic          full, head_valid, push, pop;
    logic          in_run, start_acc, hit, stale;
    logic [CW-1:0] head_stamp;
    logic [3:0]    head_mask;
    logic [31:0]   head_data, obs;
    logic [3:0]    mism;
    logic [2:0]    add;
    logic [8:0]    err_sum;

    assign full       = (count_q == FullCnt);
    assign head_valid = (count_q != '0);
    assign push       = exp_if.exp_valid && !full;
    assign head_stamp = stamp_mem[rd_ptr_q];
    assign head_mask  = mask_mem[rd_ptr_q];
    assign head_data  = data_mem[rd_ptr_q];
    assign obs        = {d, c, b, a};

    assign in_run    = (state_q == StRun);
    assign start_acc = start && !in_run;
    assign hit       = in_run && head_valid && (head_stamp == cyc_q);
    assign stale     = in_run && head_valid && (head_stamp < cyc_q);
    assign pop       = hit || stale;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            mism[i] = head_mask[i] && (obs[8*i +: 8] != head_data[8*i +: 8]);
        end
    end

    // A stale entry counts as a single error regardless of its mask.
    always_comb begin
        add = 3'd0;
        if (hit) begin
            add = {2'b0, mism[0]} + {2'b0, mism[1]} + {2'b0, mism[2]} + {2'b0, mism[3]};
        end else if (stale) begin
            add = 3'd1;
        end
    end

    assign err_sum = {1'b0, err_q} + {6'b0, add};

    always_comb begin
        state_d  = state_q;
        cyc_d    = cyc_q;
        last_d   = last_q;
        err_d    = err_q;
        missed_d = missed_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (start_acc) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (cyc_q == last_q) begin
                    state_d = StDone;
                end
            end
            default: state_d = StIdle;
        endcase

        if (start_acc) begin
            cyc_d    = '0;
            last_d   = (run_len == '0) ? '0 : run_len - 1'b1;
            err_d    = '0;
            missed_d = 1'b0;
        end else begin
            if (in_run) begin
                cyc_d = cyc_q + 1'b1;
            end
            if (pop) begin
                err_d = err_sum[8] ? 8'hFF : err_sum[7:0];
            end
            if (stale) begin
                missed_d = 1'b1;
            end
        end
    end

    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            cyc_q    <= '0;
            last_q   <= '0;
            err_q    <= '0;
            missed_q <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            cyc_q    <= cyc_d;
            last_q   <= last_d;
            err_q    <= err_d;
            missed_q <= missed_d;
            count_q  <= count_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    // Storage needs no reset: entries are only read while count_q says valid.
    always_ff @(posedge clk) begin
        if (push) begin
            stamp_mem[wr_ptr_q] <= exp_if.exp_stamp;
            mask_mem[wr_ptr_q]  <= exp_if.exp_mask;
            data_mem[wr_ptr_q]  <= {exp_if.exp_d, exp_if.exp_c, exp_if.exp_b, exp_if.exp_a};
        end
    end

`ifdef OUT_CHECKER_TRACE_EN
    logic          trace_hit_q;
    logic [CW-1:0] fail_cycle_q;
    logic [1:0]    fail_chan_q;
    logic          err_event;
    logic [1:0]    first_chan;

    assign err_event = stale || (hit && (mism != 4'b0000));

    // Stale entries report channel 0; otherwise the lowest mismatching lane.
    always_comb begin
        first_chan = 2'd0;
        if (!stale) begin
            if (mism[0])      first_chan = 2'd0;
            else if (mism[1]) first_chan = 2'd1;
            else if (mism[2]) first_chan = 2'd2;
            else              first_chan = 2'd3;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            trace_hit_q  <= 1'b0;
            fail_cycle_q <= '0;
            fail_chan_q  <= '0;
        end else if (start_acc) begin
            trace_hit_q  <= 1'b0;
            fail_cycle_q <= '0;
            fail_chan_q  <= '0;
        end else if (err_event && !trace_hit_q) begin
            trace_hit_q  <= 1'b1;
            fail_cycle_q <= cyc_q;
            fail_chan_q  <= first_chan;
        end
    end

    assign fail_cycle = fail_cycle_q;
    assign fail_chan  = fail_chan_q;
`else
    assign fail_cycle = '0;
    assign fail_chan  = '0;
`endif

    assign exp_if.exp_ready = !full;
    assign busy    = (state_q == StRun);
    assign done    = (state_q == StDone);
    assign pass    = done && (err_q == 8'd0) && (count_q == '0);
    assign err_cnt = err_q;
    assign missed  = missed_q;

endmodule

// File: tb/tb_out_checker.sv
// Scoreboard bench for out_checker: each run pushes its expected verdict into
// a queue; a monitor pops and compares when done rises.
module tb_out_checker;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = 16;
`ifdef OUT_CHECKER_TRACE_EN
    localparam bit TraceEn = 1'b1;
`else
    localparam bit TraceEn = 1'b0;
`endif

    logic          clk;
    logic          rst;
    logic [7:0]    a, b, c, d;
    logic          start;
    logic [CW-1:0] run_len;
    logic          busy, done, pass, missed;
    logic [7:0]    err_cnt;
    logic [CW-1:0] fail_cycle;
    logic [1:0]    fail_chan;

    out_checker_if #(.CW(CW)) exp_if ();

    out_checker #(
        .DEPTH(DEPTH),
        .CW   (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .a         (a),
        .b         (b),
        .c         (c),
        .d         (d),
        .start     (start),
        .run_len   (run_len),
        .exp_if    (exp_if),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .err_cnt   (err_cnt),
        .missed    (missed),
        .fail_cycle(fail_cycle),
        .fail_chan (fail_chan)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int err;
        int pass_v;
        int missed_v;
        int fcyc;
        int fchan;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_err    = 0;

    task automatic chk(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    function automatic exp_t mk(input int e, input int p, input int m, input int fc, input int fch);
        exp_t r;
        r.err      = e;
        r.pass_v   = p;
        r.missed_v = m;
        r.fcyc     = TraceEn ? fc : 0;
        r.fchan    = TraceEn ? fch : 0;
        return r;
    endfunction

    // Monitor: one verdict per rising done
    initial begin
        bit   prev;
        exp_t e;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (done && !prev) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_err++;
                    $display("FAIL unexpected_done: got done=1, expected no run pending");
                end else begin
                    e = sb_q.pop_front();
                    chk("run_err_cnt", int'(err_cnt), e.err);
                    chk("run_pass", int'(pass), e.pass_v);
                    chk("run_missed", int'(missed), e.missed_v);
                    chk("run_fail_cycle", int'(fail_cycle), e.fcyc);
                    chk("run_fail_chan", int'(fail_chan), e.fchan);
                end
            end
            prev = done;
        end
    end

    task automatic set_entry(input int stamp, input logic [3:0] mask, input logic [7:0] ea,
                             input logic [7:0] eb, input logic [7:0] ec, input logic [7:0] ed);
        exp_if.exp_valid = 1'b1;
        exp_if.exp_stamp = CW'(stamp);
        exp_if.exp_mask  = mask;
        exp_if.exp_a     = ea;
        exp_if.exp_b     = eb;
        exp_if.exp_c     = ec;
        exp_if.exp_d     = ed;
    endtask

    task automatic push_entry(input int stamp, input logic [3:0] mask, input logic [7:0] ea,
                              input logic [7:0] eb, input logic [7:0] ec, input logic [7:0] ed);
        set_entry(stamp, mask, ea, eb, ec, ed);
        @(posedge clk);
        #1;
        exp_if.exp_valid = 1'b0;
    endtask

    task automatic start_run(input int len, input bit expect_done, input exp_t e);
        if (expect_done) sb_q.push_back(e);
        start   = 1'b1;
        run_len = CW'(len);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Per-cycle stimulus of each scenario; k is the run cycle index.
    task automatic drive_cycle(input int id, input int k);
        a = 8'd0; b = 8'd0; c = 8'd0; d = 8'd0;
        start = 1'b0;
        exp_if.exp_valid = 1'b0;
        case (id)
            1: begin
                a     = (k >= 19) ? 8'd16 : 8'd0;
                c     = (k == 20) ? 8'd1 : 8'd0;
                start = (k == 12);
            end
            2: a = (k >= 19) ? 8'd16 : 8'd0;
            4: if (k == 5) set_entry(3, 4'hF, 8'd0, 8'd0, 8'd0, 8'd0);
            5: if (k < 70) set_entry(k + 2, 4'hF, 8'hAA, 8'hAA, 8'hAA, 8'hAA);
            default: ;
        endcase
    endtask

    task automatic run_checks(input int id, input int k, input int len);
        if (id == 1 && k == len - 1) begin
            chk("busy_last_cycle", int'(busy), 1);
            chk("done_last_cycle", int'(done), 0);
        end
        if (id == 4 && k == 7) begin
            chk("stale_err_cnt", int'(err_cnt), 1);
            chk("stale_missed", int'(missed), 1);
        end
        if (id == 5 && k == 10) chk("sat_mid_err_cnt", int'(err_cnt), 32);
    endtask

    task automatic do_run(input int id, input int len);
        for (int k = 0; k < len; k++) begin
            drive_cycle(id, k);
            @(negedge clk);
            run_checks(id, k, len);
            @(posedge clk);
            #1;
        end
        drive_cycle(0, 0);
    endtask

    initial begin
        rst = 1'b0;
        a = 8'd0; b = 8'd0; c = 8'd0; d = 8'd0;
        start   = 1'b0;
        run_len = '0;
        exp_if.exp_valid = 1'b0;
        exp_if.exp_stamp = '0;
        exp_if.exp_mask  = '0;
        exp_if.exp_a = 8'd0; exp_if.exp_b = 8'd0; exp_if.exp_c = 8'd0; exp_if.exp_d = 8'd0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_pass", int'(pass), 0);
        chk("rst_err_cnt", int'(err_cnt), 0);
        chk("rst_missed", int'(missed), 0);
        chk("rst_fail_cycle", int'(fail_cycle), 0);
        chk("rst_fail_chan", int'(fail_chan), 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_exp_ready", int'(exp_if.exp_ready), 1);
        @(posedge clk);
        #1;

        // Matching run, plus a start pulse mid-run that must be ignored
        push_entry(19, 4'hF, 8'd16, 8'd0, 8'd0, 8'd0);
        push_entry(20, 4'hF, 8'd16, 8'd0, 8'd1, 8'd0);
        start_run(25, 1'b1, mk(0, 1, 0, 0, 0));
        do_run(1, 25);

        // Channel c wrong at cycle 20
        push_entry(19, 4'hF, 8'd16, 8'd0, 8'd0, 8'd0);
        push_entry(20, 4'hF, 8'd16, 8'd0, 8'd1, 8'd0);
        start_run(25, 1'b1, mk(1, 0, 0, 20, 2));
        do_run(2, 25);

        // Fill to DEPTH with masked-off entries; the extra push must be dropped
        for (int i = 0; i <= int'(DEPTH); i++) begin
            if (i < int'(DEPTH)) set_entry(i, 4'h0, 8'h11, 8'h22, 8'h33, 8'h44);
            else                 set_entry(i, 4'hF, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
            @(negedge clk);
            chk($sformatf("fill_ready_%0d", i), int'(exp_if.exp_ready), (i < int'(DEPTH)) ? 1 : 0);
            @(posedge clk);
            #1;
        end
        exp_if.exp_valid = 1'b0;
        start_run(8, 1'b1, mk(0, 1, 0, 0, 0));
        do_run(3, 8);
        @(negedge clk);
        chk("drain_ready", int'(exp_if.exp_ready), 1);
        @(posedge clk);
        #1;

        // Stale entry pushed at cycle 5 with stamp 3
        start_run(10, 1'b1, mk(1, 0, 1, 6, 0));
        do_run(4, 10);

        // Seventy all-wrong entries saturate the counter
        start_run(75, 1'b1, mk(255, 0, 0, 2, 0));
        do_run(5, 75);

        // Reset mid-run with entries queued
        push_entry(2, 4'hF, 8'hAA, 8'hAA, 8'hAA, 8'hAA);
        push_entry(50, 4'hF, 8'h55, 8'h55, 8'h55, 8'h55);
        push_entry(51, 4'hF, 8'h55, 8'h55, 8'h55, 8'h55);
        start_run(20, 1'b0, mk(0, 0, 0, 0, 0));
        for (int k = 0; k < 10; k++) begin
            drive_cycle(6, k);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        chk("pre_rst_err_cnt", int'(err_cnt), 4);
        chk("pre_rst_busy", int'(busy), 1);
        #1;
        rst = 1'b0;
        #1;
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_done", int'(done), 0);
        chk("mid_rst_pass", int'(pass), 0);
        chk("mid_rst_err_cnt", int'(err_cnt), 0);
        chk("mid_rst_missed", int'(missed), 0);
        chk("mid_rst_fail_cycle", int'(fail_cycle), 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", int'(exp_if.exp_ready), 1);
        chk("post_rst_busy", int'(busy), 0);
        @(posedge clk);
        #1;

        // Queued entries must be gone: a run past their stamps stays clean
        start_run(60, 1'b1, mk(0, 1, 0, 0, 0));
        do_run(7, 60);

        for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(posedge clk);
        if (sb_q.size() != 0) begin
            n_checks++;
            n_err++;
            $display("FAIL missing_done: got %0d runs without done, expected 0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/out_checker.md
OUT_CHECKER -- requirements
Module: out_checker

Interface
REQ-001 Parameter DEPTH, 4, expectation FIFO entries (power of two, 2..16).
REQ-002 Parameter CW, 16, cycle-stamp and run-length width.
REQ-003 Port clk  input  1  rising-edge clock, single clock domain.
REQ-004 Port rst  input  1  asynchronous active-low reset.
REQ-005 Port a, b, c, d  input  8 each  observed outputs of the upstream generated top.
REQ-006 Port start  input  1  one-cycle pulse that begins a check run.
REQ-007 Port run_len  input  CW  run length in cycles, sampled on accepted start.
REQ-008 Port exp_valid / exp_ready  input / output  1  expectation push handshake.
REQ-009 Port exp_stamp  input  CW  cycle index at which the entry is checked.
REQ-010 Port exp_mask  input  4  channel enables, bit0=a .. bit3=d.
REQ-011 Port exp_a, exp_b, exp_c, exp_d  input  8 each  expected values.
REQ-012 Port busy, done, pass  output  1  run state and verdict.
REQ-013 Port err_cnt  output  8  accumulated mismatch count.
REQ-014 Port missed  output  1  sticky: an entry was never checked at its stamp.
REQ-015 Port fail_cycle, fail_chan  output  CW, 2  first-failure trace.

Function
REQ-016 FSM states IDLE, RUN, DONE; reset state IDLE.
REQ-017 IDLE/DONE + start -> RUN; cyc cleared to 0; err_cnt, missed, trace cleared; FIFO contents kept.
REQ-018 start in RUN ignored.
REQ-019 RUN: cyc increments by 1 per cycle; on cyc == run_len-1 -> DONE next cycle; run_len 0 treated as 1.
REQ-020 Push accepted when exp_valid && exp_ready; exp_ready = !full, in any state.
REQ-021 Push while full: entry dropped, no state change.
REQ-022 Push and pop in the same cycle: both occur, count unchanged; pop while empty: no pop.
REQ-023 RUN, head valid, head stamp == cyc: compare each masked channel against current a..d, pop head.
REQ-024 Mismatches in one compare add their popcount (0..4) to err_cnt.
REQ-025 RUN, head stamp < cyc: pop, err_cnt += 1, set missed; at most one pop per cycle.
REQ-026 err_cnt saturates at 255, no wrap.
REQ-027 Outputs are registered; err_cnt, missed and trace reflect a compare one cycle after it.
REQ-028 busy = (state == RUN); done = (state == DONE).
REQ-029 pass = done && err_cnt == 0 && FIFO empty; entries left unchecked at DONE make pass 0.
REQ-030 Mask 0000 entry: popped at its stamp, never an error.

Reset
REQ-031 rst low asynchronously forces IDLE; cyc, err_cnt, FIFO pointers/count, busy, done, pass, missed, fail_cycle, fail_chan to 0; exp_ready 1 after release.
REQ-032 Reset mid-run discards the run and all FIFO entries.

Configuration
REQ-033 Macro OUT_CHECKER_TRACE_EN defined: the first error of a run latches fail_cycle = cyc and fail_chan = lowest mismatching channel index (stale entry: fail_chan 0); later errors do not overwrite.
REQ-034 Macro OUT_CHECKER_TRACE_EN absent: fail_cycle and fail_chan are constant 0; trace registers not built; all other behaviour identical.

Verification
REQ-035 Push {19, 1111, 16,0,0,0} and {20, 1111, 16,0,1,0}; run_len 25; DUT drives a=16 from cycle 19, c=1 at cycle 20 -> done at cycle 25, err_cnt 0, pass 1.
REQ-036 Same entries, DUT c=0 at cycle 20 -> err_cnt 1, pass 0; with trace: fail_cycle 20, fail_chan 2.
REQ-037 Push DEPTH+1 entries with no start -> exp_ready 0 after DEPTH pushes; last entry dropped; count stays DEPTH.
REQ-038 Entry stamp 3 pushed at cyc 5 of a run -> popped next cycle, err_cnt 1, missed 1.
REQ-039 All four channels wrong at 70 entries -> err_cnt stops at 255.
REQ-040 rst low at cyc 10 of a run with 2 entries queued -> IDLE, err_cnt 0, FIFO empty, busy 0, pass 0.
